seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_CYCLES, default 12500, meaning clk cycles from one digit's completion to the next digit's start (250 us at 50 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 4096, meaning maximum clk cycles spent waiting in one handshake phase before the digit is abandoned.
REQ-003 Port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 Port value, input, 16, meaning four hex nibbles; digit k shows value[4k+3:4k].
REQ-006 Port value_load, input, 1, meaning a single-cycle strobe that captures value, dp_mask and blank_mask into shadow registers.
REQ-007 Port dp_mask, input, 4, meaning bit k = 1 lights the decimal point of digit k.
REQ-008 Port blank_mask, input, 4, meaning bit k = 1 turns off all segments of digit k.
REQ-009 Port busy, input, 1, meaning the serial driver's busy flag.
REQ-010 Port seg_data, output, 8, meaning active-low segment pattern with bit order {dp,g,f,e,d,c,b,a}.
REQ-011 Port digit_sel, output, 4, meaning the active digit index, 0 to 3.
REQ-012 Port start, output, 1, meaning the transfer request to the serial driver.
REQ-013 Port frame_done, output, 1, meaning a one-cycle pulse after digit 3 completes.
REQ-014 Port ack_err, output, 1, meaning a one-cycle pulse when a handshake phase times out.

Function
REQ-015 The FSM SHALL have the states WAIT_TICK, LOAD, REQ, WAIT_DONE and NEXT.
REQ-016 WAIT_TICK: the refresh counter SHALL count up to REFRESH_CYCLES-1, then go to LOAD.
REQ-017 LOAD (1 cycle): seg_data SHALL be registered from the active shadow, then go to REQ.
REQ-018 REQ: start SHALL be held at 1 until busy=1 is sampled, then start SHALL go to 0 and the FSM SHALL go to WAIT_DONE.
  - start is a level held until acknowledged, because the driver samples it on a slow divided clock.
REQ-019 WAIT_DONE: the FSM SHALL wait for busy=0, then go to NEXT.
REQ-020 NEXT (1 cycle): digit_sel SHALL advance 0→1→2→3→0; on the 3→0 wrap, frame_done SHALL pulse; then go to WAIT_TICK.
REQ-021 In REQ or WAIT_DONE, after ACK_TIMEOUT cycles the FSM SHALL drop start, pulse ack_err, and go to NEXT; scanning never stalls.
REQ-022 seg_data and digit_sel SHALL stay stable from LOAD until NEXT.
REQ-023 Encoding for hex 0-F (dp off): C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
REQ-024 A dp_mask bit SHALL clear bit 7; a blank_mask bit SHALL force FF, with blank taking priority over dp.
REQ-025 The shadow registers SHALL be copied to the active registers only in NEXT on the 3→0 wrap, so there is no frame tearing.
REQ-026 If value_load and the wrap occur in the same cycle, the newly loaded value SHALL become active.
REQ-027 Back-to-back value_load pulses: the last one wins.
REQ-028 If busy is already 1 on entry to REQ, the acknowledge SHALL be taken on that first REQ cycle.

Reset
REQ-029 On rst_n=0, the FSM SHALL go to WAIT_TICK with the refresh counter at 0.
REQ-030 Reset values: digit_sel=0, seg_data=FF, start=0, frame_done=0, ack_err=0, shadow and active value=0, dp_mask=0, blank_mask=F (display dark until the first load).
REQ-031 Reset mid-transfer SHALL drop start immediately, asynchronously.

Structure
REQ-032 The shared package SHALL hold the state encoding, the 16-entry segment table constant, and the SEG_BLANK=8'hFF constant.
REQ-033 There SHALL be one sub-module, seg_hex_encode (combinational): inputs nibble, dp and blank; output 8-bit pattern.

Verification
REQ-034 value_load with value=16'h3210, masks 0, REFRESH_CYCLES=4 → successive transfers (digit_sel,seg_data) = (0,C0),(1,F9),(2,A4),(3,B0), then one frame_done pulse.
REQ-035 Driver model raising busy 700 cycles after start → start held for exactly those 700 cycles, then 0; no ack_err.
REQ-036 value_load of 16'hFFFF during digit 1 of a frame → remaining digits of that frame keep the old value; the next frame shows 8E ×4.
REQ-037 dp_mask=4'b0001, blank_mask=4'b1000, value=16'h8888 → digit 0 = 00, digits 1-2 = 80, digit 3 = FF.
REQ-038 busy tied to 0 with ACK_TIMEOUT=16 → start high for 16 cycles, one ack_err pulse per digit, digit_sel still cycles 0-3.
REQ-039 rst_n pulsed low while in WAIT_DONE → start=0, digit_sel=0 and seg_data=FF immediately; after release, scanning restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM state
// encoding, the hex-to-segment table and the all-off pattern.
package seg_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_TICK = 3'd0,
        ST_LOAD      = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4
    } state_t;

    // Active-low segments, bit order {dp,g,f,e,d,c,b,a}.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry [n] is the pattern for hex digit n with the decimal point off.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg_hex_encode.sv
// Combinational nibble-to-segment encoder. Blank overrides the decimal point.
module seg_hex_encode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] pattern_o
);

    // Table lookup, then dp (active low on bit 7), then blank wins over both.
    always_comb begin
        pattern_o = SEG_TABLE[nibble_i];
        if (dp_i) begin
            pattern_o[7] = 1'b0;
        end
        if (blank_i) begin
            pattern_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller. Each digit in turn is encoded,
// handed to a serial driver through a start/busy handshake, and followed by
// a refresh gap. New display contents are staged in shadow registers and
// only become visible at the frame boundary, so a frame is never torn.
//
// Handshake: start is a level that stays high while the FSM is in REQ and
// falls on the cycle after busy=1 is sampled (the driver runs on a slow
// divided clock and may take many cycles to notice). The transfer is then
// complete once busy=0 is sampled. Either phase gives up after ACK_TIMEOUT
// cycles, pulses ack_err and moves on, so the scan never stalls.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_CYCLES = 12500,
    parameter int ACK_TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        value_load,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    input  logic        busy,
    output logic [7:0]  seg_data,
    output logic [3:0]  digit_sel,
    output logic        start,
    output logic        frame_done,
    output logic        ack_err,
    output state_t      dbg_state_o
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t         state_q, state_d;
    logic [RW-1:0]  refresh_q, refresh_d;
    logic [AW-1:0]  timeout_q, timeout_d;
    logic [1:0]     digit_q, digit_d;
    logic [7:0]     seg_q, seg_d;
    logic           frame_done_q, frame_done_d;
    logic           ack_err_q, ack_err_d;
    logic [15:0]    sh_value_q, sh_value_d, act_value_q, act_value_d;
    logic [3:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [3:0]     sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [7:0]     enc_pattern;

    seg_hex_encode u_encode (
        .nibble_i  (act_value_q[{digit_q, 2'b00} +: 4]),
        .dp_i      (act_dp_q[digit_q]),
        .blank_i   (act_blank_q[digit_q]),
        .pattern_o (enc_pattern)
    );

    // Next-state logic: scan sequencing, handshake timeouts, shadow staging.
    always_comb begin
        state_d      = state_q;
        refresh_d    = refresh_q;
        timeout_d    = timeout_q;
        digit_d      = digit_q;
        seg_d        = seg_q;
        frame_done_d = 1'b0;
        ack_err_d    = 1'b0;
        sh_value_d   = sh_value_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;

        if (value_load) begin
            sh_value_d = value;
            sh_dp_d    = dp_mask;
            sh_blank_d = blank_mask;
        end

        case (state_q)
            ST_WAIT_TICK: begin
                if (refresh_q == RW'(REFRESH_CYCLES - 1)) begin
                    refresh_d = '0;
                    state_d   = ST_LOAD;
                end else begin
                    refresh_d = refresh_q + RW'(1);
                end
            end
            ST_LOAD: begin
                seg_d     = enc_pattern;
                timeout_d = '0;
                state_d   = ST_REQ;
            end
            ST_REQ: begin
                if (busy) begin
                    timeout_d = '0;
                    state_d   = ST_WAIT_DONE;
                end else if (timeout_q == AW'(ACK_TIMEOUT - 1)) begin
                    ack_err_d = 1'b1;
                    state_d   = ST_NEXT;
                end else begin
                    timeout_d = timeout_q + AW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!busy) begin
                    state_d = ST_NEXT;
                end else if (timeout_q == AW'(ACK_TIMEOUT - 1)) begin
                    ack_err_d = 1'b1;
                    state_d   = ST_NEXT;
                end else begin
                    timeout_d = timeout_q + AW'(1);
                end
            end
            ST_NEXT: begin
                digit_d = digit_q + 2'd1;
                if (digit_q == 2'd3) begin
                    // Frame boundary: a load arriving this very cycle is taken.
                    frame_done_d = 1'b1;
                    act_value_d  = sh_value_d;
                    act_dp_d     = sh_dp_d;
                    act_blank_d  = sh_blank_d;
                end
                state_d = ST_WAIT_TICK;
            end
            default: begin
                state_d = ST_WAIT_TICK;
            end
        endcase
    end

    // State and datapath registers; reset leaves the display dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT_TICK;
            refresh_q    <= '0;
            timeout_q    <= '0;
            digit_q      <= 2'd0;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
            ack_err_q    <= 1'b0;
            sh_value_q   <= 16'h0000;
            sh_dp_q      <= 4'h0;
            sh_blank_q   <= 4'hF;
            act_value_q  <= 16'h0000;
            act_dp_q     <= 4'h0;
            act_blank_q  <= 4'hF;
        end else begin
            state_q      <= state_d;
            refresh_q    <= refresh_d;
            timeout_q    <= timeout_d;
            digit_q      <= digit_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            ack_err_q    <= ack_err_d;
            sh_value_q   <= sh_value_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
        end
    end

    // start is decoded from the state register, so reset clears it at once.
    assign start       = (state_q == ST_REQ);
    assign seg_data    = seg_q;
    assign digit_sel   = {2'b00, digit_q};
    assign frame_done  = frame_done_q;
    assign ack_err     = ack_err_q;
    assign dbg_state_o = state_q;

endmodule
